// File: rtl/uart_tx_arb_pkg.sv
// Shared constants for the UART transmit arbiter: FSM state encoding and
// default sizing for the requester count and busy-rise watchdog.
package uart_tx_arb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE      = 2'd0;
    localparam state_t ST_START     = 2'd1;
    localparam state_t ST_WAIT_BUSY = 2'd2;
    localparam state_t ST_WAIT_DONE = 2'd3;

    localparam int NREQ_DEF = 4;
    localparam int WDOG_DEF = 7;

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Rotating winner picker: the search starts one past i_last and wraps, so
// the requester just served has the lowest priority on the next pick.
module uart_rr_pick
    import uart_tx_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [2:0]      i_last,
    output logic [NREQ-1:0] o_onehot,
    output logic [2:0]      o_idx,
    output logic            o_valid
);

    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = 3'd0;
        for (int k = NREQ; k >= 1; k--) begin
            for (int i = 0; i < NREQ; i++) begin
                if (i_req[i] && (i == (int'(i_last) + k) % NREQ)) begin
                    o_valid = 1'b1;
                    o_idx   = 3'(i);
                end
            end
        end
    end

    always_comb begin
        o_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            o_onehot[i] = o_valid && (o_idx == 3'(i));
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Arbitrates NREQ byte requesters onto one UART byte transmitter.
// Define UART_TX_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int WDOG = WDOG_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   ack,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic [2:0]        grant_id,
    output logic              active,
    output logic              err
);

    localparam int              WD_W    = $clog2(WDOG + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG - 1);
    localparam logic [2:0]      PTR_RST = 3'(NREQ - 1);

    state_t            r_state;
    logic [NREQ-1:0]   r_ack;
    logic [7:0]        r_tx_data;
    logic [2:0]        r_grant;
    logic              r_err;
    logic [WD_W-1:0]   r_wdog;

    logic [2:0]        w_ptr;
    logic [NREQ-1:0]   w_onehot;
    logic [2:0]        w_idx;
    logic              w_valid;
    logic [7:0]        w_byte;

`ifdef UART_TX_ARB_FIXED_PRIO_EN
    // Pinning the pointer at the top index makes the picker start at index 0.
    assign w_ptr = PTR_RST;
`else
    assign w_ptr = r_grant;
`endif

    uart_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .i_req    (req),
        .i_last   (w_ptr),
        .o_onehot (w_onehot),
        .o_idx    (w_idx),
        .o_valid  (w_valid)
    );

    always_comb begin
        w_byte = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (w_onehot[i]) w_byte = req_data[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_ack     <= '0;
            r_tx_data <= 8'h00;
            r_grant   <= PTR_RST;
            r_err     <= 1'b0;
            r_wdog    <= '0;
        end else begin
            r_ack <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_state   <= ST_START;
                        r_ack     <= w_onehot;
                        r_tx_data <= w_byte;
                        r_grant   <= w_idx;
                    end
                end
                ST_START: begin
                    r_state <= ST_WAIT_BUSY;
                    r_wdog  <= '0;
                end
                ST_WAIT_BUSY: begin
                    // A transmitter that never acknowledges must not stall the arbiter.
                    if (tx_busy) begin
                        r_state <= ST_WAIT_DONE;
                    end else if (r_wdog == WD_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_wdog <= r_wdog + WD_W'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ack      = r_ack;
    assign tx_data  = r_tx_data;
    assign tx_start = (r_state == ST_START);
    assign grant_id = r_grant;
    assign active   = (r_state != ST_IDLE);
    assign err      = r_err;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: transaction-level reference model,
// scripted transmitter, directed scenarios and a randomized soak.
module tb_uart_tx_arb;

    localparam int NREQ = 4;
    localparam int WDOG = 7;

    logic              clk      = 1'b0;
    logic              rst      = 1'b1;
    logic [NREQ-1:0]   req      = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic              tx_busy  = 1'b0;
    logic [NREQ-1:0]   ack;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic [2:0]        grant_id;
    logic              active;
    logic              err;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx_arb #(.NREQ(NREQ), .WDOG(WDOG)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .grant_id (grant_id),
        .active   (active),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Reference model: one transfer is "open" from acceptance until the
    // transmitter handshake completes or the watchdog expires.
    int              edge_n    = 0;
    bit              m_busy    = 0;
    bit              m_gotbusy = 0;
    bit              m_err     = 0;
    bit              m_start   = 0;
    logic [NREQ-1:0] m_ack     = '0;
    logic [7:0]      m_data    = 8'h00;
    int              m_last    = NREQ - 1;
    int              m_t0      = 0;

    // Transmitter script: busy high for x_len cycles starting x_d cycles after start.
    bit x_on   = 0;
    bit x_rand = 0;
    int x_d    = 1;
    int x_len  = 1;
    int x_t0   = -1000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] r, input int last);
`ifdef UART_TX_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++) if (r[i]) return i;
        if (last < 0) return -1;
`else
        for (int k = 1; k <= NREQ; k++) if (r[(last + k) % NREQ]) return (last + k) % NREQ;
`endif
        return -1;
    endfunction

    function automatic int ack_idx(input logic [NREQ-1:0] a);
        for (int i = 0; i < NREQ; i++) if (a[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_gotbusy = 0; m_err = 0; m_start = 0;
        m_ack = '0; m_data = 8'h00; m_last = NREQ - 1;
        x_on = 0; x_t0 = -1000;
    endtask

    task automatic model_edge();
        int w;
        int r;
        edge_n++;
        m_ack   = '0;
        m_start = 0;
        if (!m_busy) begin
            w = pick(req, m_last);
            if (w >= 0) begin
                m_busy    = 1;
                m_gotbusy = 0;
                m_t0      = edge_n;
                m_last    = w;
                m_data    = req_data[8*w +: 8];
                m_ack[w]  = 1'b1;
                m_start   = 1;
                x_t0      = edge_n;
                if (x_rand) begin
                    r = int'($urandom_range(0, 9));
                    x_on  = (r != 0);
                    x_d   = (r == 1) ? WDOG + 1 : (r == 2) ? WDOG : int'($urandom_range(1, 3));
                    x_len = int'($urandom_range(1, 6));
                end
            end
        end else if (edge_n - m_t0 >= 2) begin
            if (!m_gotbusy) begin
                if (tx_busy) m_gotbusy = 1;
                else if (edge_n - m_t0 == WDOG + 1) begin
                    m_err  = 1;
                    m_busy = 0;
                end
            end else if (!tx_busy) begin
                m_busy = 0;
            end
        end
    endtask

    task automatic compare_all();
        chk("ack",      32'(ack),      32'(m_ack));
        chk("tx_start", 32'(tx_start), 32'(m_start));
        chk("tx_data",  32'(tx_data),  32'(m_data));
        chk("grant_id", 32'(grant_id), 32'(m_last));
        chk("active",   32'(active),   32'(m_busy));
        chk("err",      32'(err),      32'(m_err));
    endtask

    // One clock: model advances on the edge, outputs compared just after it,
    // transmitter busy for the next edge driven on the falling edge.
    task automatic step();
        @(posedge clk);
        if (rst) model_edge();
        #1;
        compare_all();
        @(negedge clk);
        tx_busy = x_on && (edge_n >= x_t0 + x_d) && (edge_n <= x_t0 + x_d + x_len - 1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        #1;
        compare_all();
        repeat (2) step();
        rst = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int n_ack, n_start, n_act, n_seen, k;
        int order[5];
        int at[5];
        int exp_order[5];

        // Reset values pinned to literals.
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("rst_ack",      32'(ack),      32'h0);
        chk("rst_tx_start", 32'(tx_start), 32'h0);
        chk("rst_tx_data",  32'(tx_data),  32'h00);
        chk("rst_grant_id", 32'(grant_id), 32'd3);
        chk("rst_active",   32'(active),   32'h0);
        chk("rst_err",      32'(err),      32'h0);
        repeat (2) step();
        rst = 1'b1;

        // Single byte from requester 0 with a long transmit.
        x_rand = 0; x_on = 1; x_d = 1; x_len = 2080;
        req = 4'b0001; req_data = 32'h0000_0055;
        step();
        chk("s1_ack",      32'(ack),      32'h1);
        chk("s1_tx_data",  32'(tx_data),  32'h55);
        chk("s1_grant_id", 32'(grant_id), 32'd0);
        n_start = int'(tx_start); n_ack = 1; n_act = int'(active);
        req = '0;
        for (int c = 0; c < 2100; c++) begin
            step();
            if (ack != '0) n_ack++;
            if (tx_start) n_start++;
            if (active) n_act++;
        end
        chk("s1_ack_count",   32'(n_ack),   32'd1);
        chk("s1_start_count", 32'(n_start), 32'd1);
        chk("s1_active_len",  32'(n_act),   32'd2082);
        chk("s1_idle",        32'(active),  32'h0);

        // All four requesting continuously: order and minimum spacing.
        do_reset();
        x_on = 1; x_d = 1; x_len = 1;
        req = 4'b1111; req_data = 32'hA3A2_A1A0;
`ifdef UART_TX_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        n_seen = 0;
        for (int c = 0; c < 60 && n_seen < 5; c++) begin
            step();
            if (ack != '0) begin
                order[n_seen] = ack_idx(ack);
                at[n_seen]    = c;
                n_seen++;
            end
        end
        chk("rr_ack_seen", 32'(n_seen), 32'd5);
        for (int i = 0; i < 5; i++) begin
            k = (i < n_seen) ? order[i] : -1;
            chk("rr_order", 32'(k), 32'(exp_order[i]));
        end
        if (n_seen >= 2) chk("rr_spacing", 32'(at[1] - at[0]), 32'd4);
        req = '0;
        repeat (6) step();

        // Transmitter never answers: watchdog, sticky err, next request served.
        do_reset();
        x_on = 0;
        req = 4'b0010; req_data = 32'h0000_3C00;
        step();
        chk("wd_ack", 32'(ack), 32'h2);
        n_act = int'(active);
        req = '0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (active) n_act++;
        end
        chk("wd_active_len", 32'(n_act),  32'd8);
        chk("wd_err",        32'(err),    32'h1);
        chk("wd_idle",       32'(active), 32'h0);
        x_on = 1; x_d = 1; x_len = 2;
        req = 4'b0100; req_data = 32'h0011_0000;
        step();
        chk("wd_next_ack",  32'(ack),     32'h4);
        chk("wd_next_data", 32'(tx_data), 32'h11);
        req = '0;
        repeat (6) step();
        chk("wd_err_sticky", 32'(err), 32'h1);

        // Reset during the busy phase of a transfer.
        do_reset();
        x_on = 1; x_d = 1; x_len = 50;
        req = 4'b1000; req_data = 32'h9A00_0000;
        step();
        req = '0;
        repeat (4) step();
        chk("mr_active", 32'(active), 32'h1);
        rst = 1'b0;
        model_reset();
        #1;
        chk("mr_ack",      32'(ack),      32'h0);
        chk("mr_tx_start", 32'(tx_start), 32'h0);
        chk("mr_tx_data",  32'(tx_data),  32'h00);
        chk("mr_grant_id", 32'(grant_id), 32'd3);
        chk("mr_active",   32'(active),   32'h0);
        repeat (2) step();
        rst = 1'b1;
        n_ack = 0;
        repeat (3) begin
            step();
            if (ack != '0) n_ack++;
        end
        chk("mr_no_ack", 32'(n_ack), 32'd0);

        // Requester 2 drops and changes its byte after acceptance.
        do_reset();
        x_on = 1; x_d = 1; x_len = 4;
        req = 4'b0100; req_data = 32'h0077_0000;
        step();
        chk("hold_first", 32'(tx_data), 32'h77);
        req = '0; req_data = 32'h00EE_0000;
        repeat (8) step();
        chk("hold_kept", 32'(tx_data), 32'h77);
        chk("hold_idle", 32'(active),  32'h0);
        req = 4'b0100;
        step();
        chk("hold_regrant_ack",  32'(ack),     32'h4);
        chk("hold_regrant_data", 32'(tx_data), 32'hEE);
        req = '0;
        repeat (8) step();

        // Randomized soak against the model.
        do_reset();
        x_rand = 1;
        for (int c = 0; c < 4000; c++) begin
            if (c == 2000) do_reset();
            if ($urandom_range(0, 3) == 0) req = NREQ'($urandom) & NREQ'($urandom);
            if ($urandom_range(0, 2) == 0) req_data = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
